xadac_dispatch: RTL and testbench
=================================

# xadac_dispatch

Routes one xadac master (core-side accelerator port) to `NumSlaves` xadac functional units (e.g. the vector-bias unit, MAC units), selecting the unit from an instruction field. Decode requests are routed combinationally. Execute requests are dispatched immediately, and responses return to the master strictly in dispatch order. An order FIFO tracks outstanding executes, and the block answers unmapped instructions locally.

## Interface
- `NumSlaves`, default 4: number of attached units, 1..8.
- `SelLsb`, default 12: LSB of the unit-select field in `instr`.
- `SelWidth`, default 3: width of the unit-select field.
- `MaxOutstanding`, default 4: order-FIFO depth, power of two ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `mst`  xadac_if.slv  -: port facing the core.
- `slv[NumSlaves]`  xadac_if.mst  -: ports facing the units.

## Operation
- sel = instr[SelLsb +: SelWidth].
  - Mapped: sel < NumSlaves.
  - Unmapped: otherwise; the request targets the local responder.
- Decode path, combinational:
  - Mapped: `slv[sel].dec_req_valid` = `mst.dec_req_valid`; `dec_req`, `dec_rsp` and `dec_rsp_valid`/`ready` are forwarded both ways.
  - All other slaves see `dec_req_valid` = 0.
  - Unmapped: `dec_rsp_valid` = `dec_req_valid`; `dec_rsp` = {id echoed, every other field 0, accept = 0}; `dec_req_ready` = `dec_rsp_valid && dec_rsp_ready`.
- Order FIFO:
  - Each entry holds {target index, local flag}.
  - Push on every `mst` exe_req handshake; pop on every `mst` exe_rsp handshake.
  - Occupancy counter 0..MaxOutstanding; read and write pointers wrap modulo MaxOutstanding.
- Execute request:
  - `slv[sel].exe_req_valid` = `mst.exe_req_valid && !full`.
  - `mst.exe_req_ready` = `slv[sel].exe_req_ready && !full`. For unmapped requests the local unit is always ready.
  - When full, the request is stalled; pop and push in the same cycle are not merged.
- Response source (head):
  - FIFO non-empty: the FIFO head entry.
  - FIFO empty: the current exe_req target (bypass). This lets single-cycle units respond in their accept cycle.
- Execute response:
  - `mst.exe_rsp_valid` = head `slv.exe_rsp_valid` and `mst.exe_rsp` = head `slv.exe_rsp`; only the head slave sees `exe_rsp_ready`.
  - Head local: the block drives `exe_rsp` = 0 except the id of the request, which is captured with the entry, and `vd_write` = 0. `exe_rsp_valid` = 1.
- A non-head slave asserting `exe_rsp_valid` is ignored; its ready is held at 0.
- Simultaneous push and pop: occupancy unchanged. With bypass on an empty FIFO, nothing is written.

## Timing
- Decode and execute forwarding: 0 cycles.
- FIFO state updates at the clock edge following the handshake.
- Reset (`rst`=1 at an edge): occupancy 0, pointers 0. While `rst` is high, all outputs are forced to 0:
  - `mst`: `dec_req_ready`, `dec_rsp_valid`, `exe_req_ready`, `exe_rsp_valid`.
  - All slaves: `dec_req_valid`, `dec_rsp_ready`, `exe_req_valid`, `exe_rsp_ready`.
- Reset mid-operation discards all outstanding entries; units are reset alongside.
- Valid must not drop before ready. Payload is stable while valid and not ready; the block preserves this on every forwarded path.
- No combinational path from `mst.exe_req_valid` to `mst.exe_rsp_ready` is introduced.

## Test plan
- Decode sel=0, id=5 → `slv[0]` sees valid and id 5; the vbias response (accept=1, rs_read[0]=1) reaches `mst` the same cycle; slaves 1-3 see valid=0.
- Decode sel=6 with NumSlaves=4 → local response the same cycle with id echoed, accept=0, all clobber/read bits 0; no slave valid.
- Single-cycle unit at sel=0, FIFO empty, exe_req id=3 with `rsp_ready` held 1 → bypass response the same cycle with id 3; occupancy stays 0.
- Slow unit at sel=1 (response 3 cycles late), then sel=0 fast request id=7 → the id=7 response is withheld until the sel=1 response pops; order is 1 then 0 and occupancy peaks at 2.
- `rsp_ready`=0 and 4 requests to a slow unit → 5th request sees `exe_req_ready`=0. One pop → stall continues that cycle, and the 5th request is accepted on the next cycle.
- Reset asserted with 3 entries outstanding → next cycle occupancy 0 and all valids/readies 0; after deassert, a fresh request with sel=2 routes correctly.

Source files
------------

// File: rtl/xadac_dispatch.sv
// Payload types shared by the xadac dispatcher and the units it feeds.
// Purely combinational type definitions; no timing of their own.
// Carried alongside valid/ready pairs on every channel.
package xadac_dispatch_pkg;

  localparam int IdWidth = 4;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0]        instr;
  } dec_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               accept;
    logic [1:0]         rs_read;
    logic [2:0]         vs_read;
    logic               rd_clobber;
    logic               vd_clobber;
  } dec_rsp_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0]        instr;
    logic [31:0]        rs1;
  } exe_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0]        rd;
    logic               rd_write;
    logic [31:0]        vd;
    logic               vd_write;
  } exe_rsp_t;

endpackage

// Routes one xadac master to NumSlaves units by an instruction field, answering unmapped ones locally.
// Latency: decode and execute forwarding are 0 cycles; order-FIFO state moves on the next edge.
// Backpressure: requests stall while the order FIFO is full; responses leave strictly in dispatch order.
module xadac_dispatch
  import xadac_dispatch_pkg::*;
#(
  parameter int NumSlaves      = 4,
  parameter int SelLsb         = 12,
  parameter int SelWidth       = 3,
  parameter int MaxOutstanding = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    mst_dec_req_valid,
  output logic                    mst_dec_req_ready,
  input  dec_req_t                mst_dec_req,
  output logic                    mst_dec_rsp_valid,
  input  logic                    mst_dec_rsp_ready,
  output dec_rsp_t                mst_dec_rsp,
  input  logic                    mst_exe_req_valid,
  output logic                    mst_exe_req_ready,
  input  exe_req_t                mst_exe_req,
  output logic                    mst_exe_rsp_valid,
  input  logic                    mst_exe_rsp_ready,
  output exe_rsp_t                mst_exe_rsp,

  output logic     [NumSlaves-1:0] slv_dec_req_valid,
  input  logic     [NumSlaves-1:0] slv_dec_req_ready,
  output dec_req_t [NumSlaves-1:0] slv_dec_req,
  input  logic     [NumSlaves-1:0] slv_dec_rsp_valid,
  output logic     [NumSlaves-1:0] slv_dec_rsp_ready,
  input  dec_rsp_t [NumSlaves-1:0] slv_dec_rsp,
  output logic     [NumSlaves-1:0] slv_exe_req_valid,
  input  logic     [NumSlaves-1:0] slv_exe_req_ready,
  output exe_req_t [NumSlaves-1:0] slv_exe_req,
  input  logic     [NumSlaves-1:0] slv_exe_rsp_valid,
  output logic     [NumSlaves-1:0] slv_exe_rsp_ready,
  input  exe_rsp_t [NumSlaves-1:0] slv_exe_rsp
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0]   CntMax  = CntW'(MaxOutstanding);
  localparam logic [SelWidth:0] NumSlvW = (SelWidth + 1)'(NumSlaves);

  logic [SelWidth-1:0] dec_sel;
  logic [SelWidth-1:0] exe_sel;
  logic                dec_mapped;
  logic                exe_mapped;

  // Order FIFO: which unit (or the local responder) owes each outstanding response.
  logic [SelWidth-1:0] fifo_sel [MaxOutstanding];
  logic                fifo_loc [MaxOutstanding];
  logic [IdWidth-1:0]  fifo_id  [MaxOutstanding];
  logic [PtrW-1:0]     wptr;
  logic [PtrW-1:0]     rptr;
  logic [CntW-1:0]     occupancy;

  logic                full;
  logic                empty;
  logic                req_tgt_rdy;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic                rd_en;

  logic                head_vld;
  logic                head_loc;
  logic [SelWidth-1:0] head_sel;
  logic [IdWidth-1:0]  head_id;

  assign dec_sel    = mst_dec_req.instr[SelLsb +: SelWidth];
  assign exe_sel    = mst_exe_req.instr[SelLsb +: SelWidth];
  assign dec_mapped = ({1'b0, dec_sel} < NumSlvW);
  assign exe_mapped = ({1'b0, exe_sel} < NumSlvW);

  // Request payloads are broadcast; only the selected unit sees valid.
  always_comb begin
    for (int i = 0; i < NumSlaves; i++) begin
      slv_dec_req[i] = mst_dec_req;
      slv_exe_req[i] = mst_exe_req;
    end
  end

  // Decode path: forward to the selected unit, or answer "not accepted" locally.
  always_comb begin
    mst_dec_req_ready = 1'b0;
    mst_dec_rsp_valid = 1'b0;
    mst_dec_rsp       = '0;
    slv_dec_req_valid = '0;
    slv_dec_rsp_ready = '0;
    if (!rst) begin
      if (dec_mapped) begin
        for (int i = 0; i < NumSlaves; i++) begin
          if (dec_sel == SelWidth'(i)) begin
            slv_dec_req_valid[i] = mst_dec_req_valid;
            slv_dec_rsp_ready[i] = mst_dec_rsp_ready;
            mst_dec_req_ready    = slv_dec_req_ready[i];
            mst_dec_rsp_valid    = slv_dec_rsp_valid[i];
            mst_dec_rsp          = slv_dec_rsp[i];
          end
        end
      end else begin
        mst_dec_rsp_valid = mst_dec_req_valid;
        mst_dec_rsp.id    = mst_dec_req.id;
        mst_dec_req_ready = mst_dec_req_valid && mst_dec_rsp_ready;
      end
    end
  end

  assign full  = (occupancy == CntMax);
  assign empty = (occupancy == '0);

  // Readiness of the execute target; the local responder never stalls.
  always_comb begin
    req_tgt_rdy = 1'b1;
    for (int i = 0; i < NumSlaves; i++) begin
      if (exe_mapped && exe_sel == SelWidth'(i)) begin
        req_tgt_rdy = slv_exe_req_ready[i];
      end
    end
  end

  assign mst_exe_req_ready = !rst && !full && req_tgt_rdy;
  assign push              = mst_exe_req_valid && mst_exe_req_ready;

  // Head selection: oldest FIFO entry, or the in-flight request when the FIFO is empty.
  always_comb begin
    if (empty) begin
      head_vld = mst_exe_req_valid;
      head_loc = !exe_mapped;
      head_sel = exe_sel;
      head_id  = mst_exe_req.id;
    end else begin
      head_vld = 1'b1;
      head_loc = fifo_loc[rptr];
      head_sel = fifo_sel[rptr];
      head_id  = fifo_id[rptr];
    end
  end

  // Execute routing: request to the selected unit, response only from the head.
  always_comb begin
    slv_exe_req_valid = '0;
    slv_exe_rsp_ready = '0;
    mst_exe_rsp_valid = 1'b0;
    mst_exe_rsp       = '0;
    if (!rst) begin
      for (int i = 0; i < NumSlaves; i++) begin
        if (exe_mapped && exe_sel == SelWidth'(i)) begin
          slv_exe_req_valid[i] = mst_exe_req_valid && !full;
        end
      end
      if (head_vld) begin
        if (head_loc) begin
          mst_exe_rsp_valid = 1'b1;
          mst_exe_rsp.id    = head_id;
        end else begin
          for (int i = 0; i < NumSlaves; i++) begin
            if (head_sel == SelWidth'(i)) begin
              mst_exe_rsp_valid    = slv_exe_rsp_valid[i];
              mst_exe_rsp          = slv_exe_rsp[i];
              slv_exe_rsp_ready[i] = mst_exe_rsp_ready;
            end
          end
        end
      end
    end
  end

  // A bypassed request answered in its accept cycle never enters the FIFO.
  assign pop   = mst_exe_rsp_valid && mst_exe_rsp_ready;
  assign wr_en = push && !(empty && pop);
  assign rd_en = pop && !empty;

  // Pointer and occupancy bookkeeping; reset discards every outstanding entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PtrW'(1);
      if (rd_en) rptr <= rptr + PtrW'(1);
      occupancy <= occupancy + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_sel[wptr] <= exe_sel;
      fifo_loc[wptr] <= !exe_mapped;
      fifo_id[wptr]  <= mst_exe_req.id;
    end
  end

endmodule

// File: tb/tb_xadac_dispatch.sv
// Directed bench for xadac_dispatch with an in-order response scoreboard.
// Slave behaviour is scripted per scenario; responses are checked on every master handshake.
// Inputs change 1 time unit after the rising edge; outputs are sampled later in the cycle.
module tb_xadac_dispatch;
  import xadac_dispatch_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst;

  logic     mst_dec_req_valid, mst_dec_req_ready;
  dec_req_t mst_dec_req;
  logic     mst_dec_rsp_valid, mst_dec_rsp_ready;
  dec_rsp_t mst_dec_rsp;
  logic     mst_exe_req_valid, mst_exe_req_ready;
  exe_req_t mst_exe_req;
  logic     mst_exe_rsp_valid, mst_exe_rsp_ready;
  exe_rsp_t mst_exe_rsp;

  logic     [N-1:0] slv_dec_req_valid, slv_dec_req_ready;
  dec_req_t [N-1:0] slv_dec_req;
  logic     [N-1:0] slv_dec_rsp_valid, slv_dec_rsp_ready;
  dec_rsp_t [N-1:0] slv_dec_rsp;
  logic     [N-1:0] slv_exe_req_valid, slv_exe_req_ready;
  exe_req_t [N-1:0] slv_exe_req;
  logic     [N-1:0] slv_exe_rsp_valid, slv_exe_rsp_ready;
  exe_rsp_t [N-1:0] slv_exe_rsp;

  int checks   = 0;
  int failures = 0;
  exe_rsp_t exp_q[$];
  exe_rsp_t sb_exp;

  xadac_dispatch #(
    .NumSlaves(N), .SelLsb(12), .SelWidth(3), .MaxOutstanding(4)
  ) dut (
    .clk(clk), .rst(rst),
    .mst_dec_req_valid(mst_dec_req_valid), .mst_dec_req_ready(mst_dec_req_ready),
    .mst_dec_req(mst_dec_req),
    .mst_dec_rsp_valid(mst_dec_rsp_valid), .mst_dec_rsp_ready(mst_dec_rsp_ready),
    .mst_dec_rsp(mst_dec_rsp),
    .mst_exe_req_valid(mst_exe_req_valid), .mst_exe_req_ready(mst_exe_req_ready),
    .mst_exe_req(mst_exe_req),
    .mst_exe_rsp_valid(mst_exe_rsp_valid), .mst_exe_rsp_ready(mst_exe_rsp_ready),
    .mst_exe_rsp(mst_exe_rsp),
    .slv_dec_req_valid(slv_dec_req_valid), .slv_dec_req_ready(slv_dec_req_ready),
    .slv_dec_req(slv_dec_req),
    .slv_dec_rsp_valid(slv_dec_rsp_valid), .slv_dec_rsp_ready(slv_dec_rsp_ready),
    .slv_dec_rsp(slv_dec_rsp),
    .slv_exe_req_valid(slv_exe_req_valid), .slv_exe_req_ready(slv_exe_req_ready),
    .slv_exe_req(slv_exe_req),
    .slv_exe_rsp_valid(slv_exe_rsp_valid), .slv_exe_rsp_ready(slv_exe_rsp_ready),
    .slv_exe_rsp(slv_exe_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [2:0] sel);
    logic [31:0] r;
    r = 32'h0000_002B;
    r[14:12] = sel;
    return r;
  endfunction

  function automatic exe_rsp_t mk_rsp(input logic [3:0] id);
    exe_rsp_t r;
    r = '0;
    r.id       = id;
    r.rd       = 32'hA000 + 32'(id);
    r.rd_write = 1'b1;
    r.vd       = 32'hB000 + 32'(id);
    r.vd_write = 1'b1;
    return r;
  endfunction

  function automatic exe_rsp_t mk_local(input logic [3:0] id);
    exe_rsp_t r;
    r = '0;
    r.id = id;
    return r;
  endfunction

  function automatic exe_req_t mk_req(input logic [3:0] id, input logic [2:0] sel);
    exe_req_t r;
    r.id    = id;
    r.instr = mk_instr(sel);
    r.rs1   = 32'h1000 + 32'(id);
    return r;
  endfunction

  // Scoreboard: every master-side execute handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mst_exe_rsp_valid && mst_exe_rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_rsp got id=%0d expected none", mst_exe_rsp.id);
      end else begin
        sb_exp = exp_q.pop_front();
        if (mst_exe_rsp !== sb_exp) begin
          failures++;
          $display("FAIL sb_rsp got id=%0d rd=%h vdw=%b expected id=%0d rd=%h vdw=%b",
                   mst_exe_rsp.id, mst_exe_rsp.rd, mst_exe_rsp.vd_write,
                   sb_exp.id, sb_exp.rd, sb_exp.vd_write);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mst_dec_req_valid = 1'b0;
    mst_dec_req       = '0;
    mst_dec_rsp_ready = 1'b0;
    mst_exe_req_valid = 1'b0;
    mst_exe_req       = '0;
    mst_exe_rsp_ready = 1'b0;
    slv_dec_req_ready = '1;
    slv_dec_rsp_valid = '0;
    slv_dec_rsp       = '0;
    slv_exe_req_ready = '1;
    slv_exe_rsp_valid = '0;
    slv_exe_rsp       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mst_dec_req_valid = 1'b1;
    mst_dec_rsp_ready = 1'b1;
    mst_exe_req_valid = 1'b1;
    mst_exe_rsp_ready = 1'b1;
    slv_dec_rsp_valid = '1;
    slv_exe_rsp_valid = '1;
    step();
    #1;
    checks++;
    if ({mst_dec_req_ready, mst_dec_rsp_valid, mst_exe_req_ready, mst_exe_rsp_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mst_outputs got %b expected 0000",
               {mst_dec_req_ready, mst_dec_rsp_valid, mst_exe_req_ready, mst_exe_rsp_valid});
    end
    checks++;
    if ({slv_dec_req_valid, slv_dec_rsp_ready, slv_exe_req_valid, slv_exe_rsp_ready} !== 16'h0) begin
      failures++;
      $display("FAIL reset_slv_outputs got %h expected 0000",
               {slv_dec_req_valid, slv_dec_rsp_ready, slv_exe_req_valid, slv_exe_rsp_ready});
    end
    checks++;
    if (dut.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL reset_occupancy got %0d expected 0", dut.occupancy);
    end
    idle();
    rst = 1'b0;
    step();
  endtask

  task automatic test_dec_mapped();
    dec_rsp_t r;
    r = '0;
    r.id = 4'd5;
    r.accept = 1'b1;
    r.rs_read = 2'b01;
    mst_dec_req.id    = 4'd5;
    mst_dec_req.instr = mk_instr(3'd0);
    mst_dec_req_valid = 1'b1;
    mst_dec_rsp_ready = 1'b1;
    slv_dec_rsp[0]    = r;
    slv_dec_rsp_valid = 4'b0001;
    #1;
    checks++;
    if (slv_dec_req_valid !== 4'b0001) begin
      failures++;
      $display("FAIL dec_map_valid got %b expected 0001", slv_dec_req_valid);
    end
    checks++;
    if (slv_dec_req[0].id !== 4'd5) begin
      failures++;
      $display("FAIL dec_map_id got %0d expected 5", slv_dec_req[0].id);
    end
    checks++;
    if (mst_dec_rsp_valid !== 1'b1 || mst_dec_rsp !== r) begin
      failures++;
      $display("FAIL dec_map_rsp got v=%b %h expected v=1 %h", mst_dec_rsp_valid, mst_dec_rsp, r);
    end
    checks++;
    if (mst_dec_req_ready !== 1'b1 || slv_dec_rsp_ready !== 4'b0001) begin
      failures++;
      $display("FAIL dec_map_ready got %b/%b expected 1/0001", mst_dec_req_ready, slv_dec_rsp_ready);
    end
    step();
    idle();
  endtask

  task automatic test_dec_unmapped();
    dec_rsp_t r;
    r = '0;
    r.id = 4'd9;
    mst_dec_req.id    = 4'd9;
    mst_dec_req.instr = mk_instr(3'd6);
    mst_dec_req_valid = 1'b1;
    mst_dec_rsp_ready = 1'b1;
    #1;
    checks++;
    if (slv_dec_req_valid !== 4'b0000) begin
      failures++;
      $display("FAIL dec_unmap_slv_valid got %b expected 0000", slv_dec_req_valid);
    end
    checks++;
    if (mst_dec_rsp_valid !== 1'b1 || mst_dec_rsp !== r) begin
      failures++;
      $display("FAIL dec_unmap_rsp got v=%b %h expected v=1 %h", mst_dec_rsp_valid, mst_dec_rsp, r);
    end
    checks++;
    if (mst_dec_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL dec_unmap_ready got %b expected 1", mst_dec_req_ready);
    end
    mst_dec_rsp_ready = 1'b0;
    #1;
    checks++;
    if (mst_dec_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL dec_unmap_ready_bp got %b expected 0", mst_dec_req_ready);
    end
    step();
    idle();
  endtask

  task automatic test_bypass();
    mst_exe_req       = mk_req(4'd3, 3'd0);
    mst_exe_req_valid = 1'b1;
    mst_exe_rsp_ready = 1'b1;
    slv_exe_rsp[0]    = mk_rsp(4'd3);
    slv_exe_rsp_valid = 4'b0001;
    exp_q.push_back(mk_rsp(4'd3));
    #1;
    checks++;
    if (slv_exe_req_valid !== 4'b0001 || mst_exe_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bypass_req got %b/%b expected 0001/1", slv_exe_req_valid, mst_exe_req_ready);
    end
    checks++;
    if (mst_exe_rsp_valid !== 1'b1 || mst_exe_rsp.id !== 4'd3) begin
      failures++;
      $display("FAIL bypass_rsp got v=%b id=%0d expected v=1 id=3", mst_exe_rsp_valid, mst_exe_rsp.id);
    end
    step();
    idle();
    #1;
    checks++;
    if (dut.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL bypass_occupancy got %0d expected 0", dut.occupancy);
    end
    step();
  endtask

  task automatic test_local();
    mst_exe_rsp_ready = 1'b1;
    mst_exe_req       = mk_req(4'd4, 3'd1);
    mst_exe_req_valid = 1'b1;
    exp_q.push_back(mk_rsp(4'd4));
    step();
    mst_exe_req = mk_req(4'd6, 3'd7);
    exp_q.push_back(mk_local(4'd6));
    #1;
    checks++;
    if (mst_exe_req_ready !== 1'b1 || mst_exe_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL local_queued got rdy=%b rspv=%b expected 1/0", mst_exe_req_ready, mst_exe_rsp_valid);
    end
    step();
    mst_exe_req_valid = 1'b0;
    mst_exe_req       = '0;
    slv_exe_rsp[1]    = mk_rsp(4'd4);
    slv_exe_rsp_valid = 4'b0010;
    step();
    slv_exe_rsp_valid = '0;
    slv_exe_rsp       = '0;
    #1;
    checks++;
    if (mst_exe_rsp_valid !== 1'b1 || mst_exe_rsp !== mk_local(4'd6)) begin
      failures++;
      $display("FAIL local_rsp got v=%b id=%0d rd=%h expected v=1 id=6 rd=0",
               mst_exe_rsp_valid, mst_exe_rsp.id, mst_exe_rsp.rd);
    end
    step();
    checks++;
    if (dut.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL local_occupancy got %0d expected 0", dut.occupancy);
    end
    idle();
  endtask

  task automatic test_order();
    mst_exe_rsp_ready = 1'b1;
    mst_exe_req       = mk_req(4'd1, 3'd1);
    mst_exe_req_valid = 1'b1;
    exp_q.push_back(mk_rsp(4'd1));
    step();
    mst_exe_req       = mk_req(4'd7, 3'd0);
    slv_exe_rsp[0]    = mk_rsp(4'd7);
    slv_exe_rsp_valid = 4'b0001;
    exp_q.push_back(mk_rsp(4'd7));
    #1;
    checks++;
    if (mst_exe_rsp_valid !== 1'b0 || slv_exe_rsp_ready !== 4'b0010) begin
      failures++;
      $display("FAIL order_withheld got v=%b rdy=%b expected 0/0010", mst_exe_rsp_valid, slv_exe_rsp_ready);
    end
    step();
    mst_exe_req_valid = 1'b0;
    mst_exe_req       = '0;
    #1;
    checks++;
    if (dut.occupancy !== 3'd2 || mst_exe_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_peak got occ=%0d v=%b expected 2/0", dut.occupancy, mst_exe_rsp_valid);
    end
    step();
    slv_exe_rsp[1]    = mk_rsp(4'd1);
    slv_exe_rsp_valid = 4'b0011;
    #1;
    checks++;
    if (mst_exe_rsp.id !== 4'd1 || slv_exe_rsp_ready !== 4'b0010) begin
      failures++;
      $display("FAIL order_first got id=%0d rdy=%b expected 1/0010", mst_exe_rsp.id, slv_exe_rsp_ready);
    end
    step();
    slv_exe_rsp_valid = 4'b0001;
    #1;
    checks++;
    if (mst_exe_rsp.id !== 4'd7 || slv_exe_rsp_ready !== 4'b0001) begin
      failures++;
      $display("FAIL order_second got id=%0d rdy=%b expected 7/0001", mst_exe_rsp.id, slv_exe_rsp_ready);
    end
    step();
    idle();
    checks++;
    if (dut.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL order_drained got %0d expected 0", dut.occupancy);
    end
  endtask

  task automatic test_full();
    mst_exe_rsp_ready = 1'b0;
    mst_exe_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mst_exe_req = mk_req(4'(10 + k), 3'd1);
      exp_q.push_back(mk_rsp(4'(10 + k)));
      #1;
      checks++;
      if (mst_exe_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_fill%0d got rdy=%b expected 1", k, mst_exe_req_ready);
      end
      step();
    end
    mst_exe_req = mk_req(4'd14, 3'd1);
    #1;
    checks++;
    if (dut.occupancy !== 3'd4 || mst_exe_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_stall got occ=%0d rdy=%b expected 4/0", dut.occupancy, mst_exe_req_ready);
    end
    step();
    slv_exe_rsp[1]    = mk_rsp(4'd10);
    slv_exe_rsp_valid = 4'b0010;
    mst_exe_rsp_ready = 1'b1;
    #1;
    checks++;
    if (mst_exe_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_cycle got rdy=%b expected 0", mst_exe_req_ready);
    end
    step();
    slv_exe_rsp_valid = '0;
    mst_exe_rsp_ready = 1'b0;
    exp_q.push_back(mk_rsp(4'd14));
    #1;
    checks++;
    if (mst_exe_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_resume got rdy=%b expected 1", mst_exe_req_ready);
    end
    step();
    mst_exe_req_valid = 1'b0;
    mst_exe_req       = '0;
    mst_exe_rsp_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      slv_exe_rsp[1]    = mk_rsp(4'(k));
      slv_exe_rsp_valid = 4'b0010;
      step();
    end
    idle();
    checks++;
    if (dut.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL full_drained got %0d expected 0", dut.occupancy);
    end
  endtask

  task automatic test_reset_mid();
    mst_exe_rsp_ready = 1'b0;
    mst_exe_req_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      mst_exe_req = mk_req(4'(k), 3'd3);
      step();
    end
    checks++;
    if (dut.occupancy !== 3'd3) begin
      failures++;
      $display("FAIL rstmid_pre got %0d expected 3", dut.occupancy);
    end
    rst = 1'b1;
    mst_dec_req_valid = 1'b1;
    mst_exe_rsp_ready = 1'b1;
    slv_exe_rsp_valid = 4'b1000;
    step();
    #1;
    checks++;
    if (dut.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_occupancy got %0d expected 0", dut.occupancy);
    end
    checks++;
    if ({mst_dec_req_ready, mst_dec_rsp_valid, mst_exe_req_ready, mst_exe_rsp_valid,
         slv_dec_req_valid, slv_dec_rsp_ready, slv_exe_req_valid, slv_exe_rsp_ready} !== 20'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got %h expected 0",
               {mst_dec_req_ready, mst_dec_rsp_valid, mst_exe_req_ready, mst_exe_rsp_valid,
                slv_dec_req_valid, slv_dec_rsp_ready, slv_exe_req_valid, slv_exe_rsp_ready});
    end
    idle();
    rst = 1'b0;
    step();
    mst_exe_req       = mk_req(4'd2, 3'd2);
    mst_exe_req_valid = 1'b1;
    mst_exe_rsp_ready = 1'b1;
    slv_exe_rsp[2]    = mk_rsp(4'd2);
    slv_exe_rsp_valid = 4'b0100;
    exp_q.push_back(mk_rsp(4'd2));
    #1;
    checks++;
    if (slv_exe_req_valid !== 4'b0100 || mst_exe_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_route got %b v=%b expected 0100/1", slv_exe_req_valid, mst_exe_rsp_valid);
    end
    step();
    idle();
    checks++;
    if (dut.occupancy !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_after got %0d expected 0", dut.occupancy);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) step();
    test_reset();
    test_dec_mapped();
    test_dec_unmapped();
    test_bypass();
    test_local();
    test_order();
    test_full();
    test_reset_mid();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
